// File: rtl/text_pkg.sv
//------------------------------------------------------------------------------
// text_pkg : character codes and FSM encoding shared by the text cursor blocks
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package text_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ECHO  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cursor_next.sv
//------------------------------------------------------------------------------
// cursor_next : next cursor position and RAM write for one received byte
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cursor_next
  import text_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 32,
  parameter int ROW_W = 2,
  parameter int COL_W = 5
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [7:0]       char_in,
  output logic [ROW_W-1:0] nxt_row,
  output logic [COL_W-1:0] nxt_col,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic             is_ff
);

  logic [ROW_W-1:0] row_inc;

  always_comb begin
    row_inc = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);

    nxt_row = row;
    nxt_col = col;
    wr_en   = 1'b0;
    wr_row  = row;
    wr_col  = col;
    wr_data = char_in;
    is_ff   = 1'b0;

    if (char_in >= PRINT_LO && char_in <= PRINT_HI) begin
      wr_en = 1'b1;
      if (col == COL_W'(COLS - 1)) begin
        nxt_col = '0;
        nxt_row = row_inc;
      end else begin
        nxt_col = col + COL_W'(1);
      end
    end else if (char_in == CHAR_CR || char_in == CHAR_LF) begin
      nxt_col = '0;
      nxt_row = row_inc;
    end else if (char_in == CHAR_BS) begin
      // Backspace blanks the cell it moves onto; at column 0 it is a no-op
      if (col != '0) begin
        nxt_col = col - COL_W'(1);
        wr_en   = 1'b1;
        wr_col  = col - COL_W'(1);
        wr_data = CHAR_SPACE;
      end
    end else if (char_in == CHAR_FF) begin
      is_ff = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/text_cursor_ctrl.sv
//------------------------------------------------------------------------------
// text_cursor_ctrl : UART byte stream to character RAM writes, echo and clear
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = 5,
  parameter int ROW_W = 2,
  parameter int ECHO  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clear_req,
  input  logic             tx_busy,
  output logic             ram_we,
  output logic [ROW_W-1:0] ram_row,
  output logic [COL_W-1:0] ram_col,
  output logic [7:0]       ram_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = ROW_W + COL_W;

  state_t           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [7:0]       cur_byte_q, cur_byte_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ram_we_q, ram_we_d;
  logic [ROW_W-1:0] ram_row_q, ram_row_d;
  logic [COL_W-1:0] ram_col_q, ram_col_d;
  logic [7:0]       ram_data_q, ram_data_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic             pend_take;
  logic [7:0]       cn_byte;
  logic [ROW_W-1:0] cn_nxt_row, cn_wr_row;
  logic [COL_W-1:0] cn_nxt_col, cn_wr_col;
  logic [7:0]       cn_wr_data;
  logic             cn_wr_en, cn_is_ff;

  // In IDLE the RAM write is registered from the pending byte so it lands in WRITE
  assign cn_byte = (state_q == ST_IDLE) ? pend_data_q : cur_byte_q;

  cursor_next #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_cursor_next (
    .row     (cur_row_q),
    .col     (cur_col_q),
    .char_in (cn_byte),
    .nxt_row (cn_nxt_row),
    .nxt_col (cn_nxt_col),
    .wr_en   (cn_wr_en),
    .wr_row  (cn_wr_row),
    .wr_col  (cn_wr_col),
    .wr_data (cn_wr_data),
    .is_ff   (cn_is_ff)
  );

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    cur_byte_d   = cur_byte_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    clr_cnt_d    = clr_cnt_q;
    ram_we_d     = 1'b0;
    ram_row_d    = ram_row_q;
    ram_col_d    = ram_col_q;
    ram_data_d   = ram_data_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    overflow_d   = overflow_q;
    pend_take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (pend_valid_q) begin
          pend_take  = 1'b1;
          cur_byte_d = pend_data_q;
          state_d    = ST_WRITE;
          ram_we_d   = cn_wr_en;
          ram_row_d  = cn_wr_row;
          ram_col_d  = cn_wr_col;
          ram_data_d = cn_wr_data;
        end
      end
      ST_WRITE: begin
        cur_row_d = cn_nxt_row;
        cur_col_d = cn_nxt_col;
        if (ECHO != 0) begin
          state_d = ST_ECHO;
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = cur_byte_q;
          end
        end else begin
          state_d = cn_is_ff ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_ECHO: begin
        // Leave once the pulse is on the output, so exactly one is issued
        if (tx_start_q) begin
          state_d = (cur_byte_q == CHAR_FF) ? ST_CLEAR : ST_IDLE;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte_q;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == '1) begin
          state_d   = ST_IDLE;
          cur_row_d = '0;
          cur_col_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_CLEAR) begin
      if (state_q != ST_CLEAR) begin
        clr_cnt_d = '0;
      end
      ram_we_d               = 1'b1;
      ram_data_d             = CHAR_SPACE;
      {ram_row_d, ram_col_d} = clr_cnt_d;
    end

    if (pend_take) begin
      pend_valid_d = 1'b0;
    end
    if (rx_valid) begin
      if (!pend_valid_q || pend_take) begin
        pend_valid_d = 1'b1;
        pend_data_d  = rx_data;
      end else begin
        overflow_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      cur_byte_q   <= '0;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      clr_cnt_q    <= '0;
      ram_we_q     <= 1'b0;
      ram_row_q    <= '0;
      ram_col_q    <= '0;
      ram_data_q   <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      cur_byte_q   <= cur_byte_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      clr_cnt_q    <= clr_cnt_d;
      ram_we_q     <= ram_we_d;
      ram_row_q    <= ram_row_d;
      ram_col_q    <= ram_col_d;
      ram_data_q   <= ram_data_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_row  = ram_row_q;
  assign ram_col  = ram_col_q;
  assign ram_data = ram_data_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_text_cursor_ctrl.sv
//------------------------------------------------------------------------------
// tb_text_cursor_ctrl : scoreboard bench for text_cursor_ctrl
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_text_cursor_ctrl;

  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int COL_W = 5;
  localparam int ROW_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             clear_req = 1'b0;
  logic             tx_busy = 1'b0;
  logic             ram_we;
  logic [ROW_W-1:0] ram_row;
  logic [COL_W-1:0] ram_col;
  logic [7:0]       ram_data;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;
  logic             overflow;

  text_cursor_ctrl #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W),
    .ECHO  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .clear_req (clear_req),
    .tx_busy   (tx_busy),
    .ram_we    (ram_we),
    .ram_row   (ram_row),
    .ram_col   (ram_col),
    .ram_data  (ram_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int tx_cnt   = 0;
  int m_row    = 0;
  int m_col    = 0;
  logic [31:0] wq[$];
  logic [31:0] txq[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int r, input int c, input logic [7:0] d);
    wq.push_back(32'((r << 13) | (c << 8) | int'(d)));
  endtask

  task automatic model_clear();
    for (int i = 0; i < ROWS * COLS; i++) push_wr(i / COLS, i % COLS, 8'h20);
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row, m_col, b);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      model_clear();
    end
    txq.push_back({24'd0, b});
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Idle means busy low for several consecutive samples (bridges IDLE gaps)
  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 600) begin
      tick();
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    if (quiet < 4) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    drive_byte(b);
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        wr_cnt++;
        if (wq.size() == 0) check("wr_unexpected", {49'd0, ram_row, ram_col, ram_data}, 64'hFFFF);
        else check("ram_wr", {49'd0, ram_row, ram_col, ram_data}, {32'd0, wq.pop_front()});
      end
      if (tx_start) begin
        tx_cnt++;
        if (txq.size() == 0) check("tx_unexpected", {56'd0, tx_data}, 64'hFFFF);
        else check("tx_byte", {56'd0, tx_data}, {32'd0, txq.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int good;
    int tx_before;
    int wr_before;

    #2;
    check("rst_outs", {30'd0, ram_we, ram_row, ram_col, ram_data, tx_start, tx_data,
                       cur_row, cur_col, busy, overflow}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", {63'd0, busy}, 64'd0);

    // 'A' with cycle-exact latency checks
    model_byte(8'h41);
    drive_byte(8'h41);
    tick();
    check("a_we_n2", {63'd0, ram_we}, 64'd1);
    check("a_addr", {57'd0, ram_row, ram_col}, 64'd0);
    check("a_data", {56'd0, ram_data}, 64'h41);
    tick();
    check("a_cursor", {57'd0, cur_row, cur_col}, 64'd1);
    check("a_tx", {55'd0, tx_start, tx_data}, 64'h141);
    wait_idle();

    // Walk to (3,31) then wrap with 'Z'
    for (int i = 0; i < 3; i++) send(8'h0D);
    for (int i = 0; i < 31; i++) send(8'h61 + 8'(i % 26));
    check("at_3_31", {57'd0, cur_row, cur_col}, 64'd127);
    send(8'h5A);
    check("wrap_00", {57'd0, cur_row, cur_col}, 64'd0);

    // (1,5) then CR, then BS at column 0, then BS mid-row, then an ignored code
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h31);
    check("at_1_5", {57'd0, cur_row, cur_col}, 64'd37);
    send(8'h0D);
    check("cr_2_0", {57'd0, cur_row, cur_col}, 64'd64);
    wr_before = wr_cnt;
    send(8'h08);
    check("bs_col0_pos", {57'd0, cur_row, cur_col}, 64'd64);
    check("bs_col0_nowr", 64'(wr_cnt - wr_before), 64'd0);
    send(8'h71);
    send(8'h08);
    check("bs_back", {57'd0, cur_row, cur_col}, 64'd64);
    send(8'h01);
    check("ignored_pos", {57'd0, cur_row, cur_col}, 64'd64);

    // Clear and 'B' in the same cycle
    model_clear();
    model_byte(8'h42);
    clear_req = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h42;
    tick();
    clear_req = 1'b0;
    rx_valid  = 1'b0;
    good = 0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (ram_we && busy) good++;
      tick();
    end
    check("clear_run", 64'(good), 64'd128);
    check("clear_end_we", {63'd0, ram_we}, 64'd0);
    wait_idle();
    check("b_cursor", {57'd0, cur_row, cur_col}, 64'd1);

    // Echo back-pressure: two bytes kept, third dropped
    tx_busy = 1'b1;
    tx_before = tx_cnt;
    model_byte(8'h61);
    model_byte(8'h62);
    drive_byte(8'h61);
    rx_valid = 1'b1;
    rx_data  = 8'h62;
    tick();
    rx_data  = 8'h63;
    tick();
    rx_valid = 1'b0;
    repeat (10) tick();
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("hold_no_tx", 64'(tx_cnt - tx_before), 64'd0);
    tx_busy = 1'b0;
    wait_idle();
    check("two_echoes", 64'(tx_cnt - tx_before), 64'd2);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset during a clear sweep
    model_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    wq.delete();
    #2;
    check("rst_mid_clear", {30'd0, ram_we, ram_row, ram_col, ram_data, tx_start, tx_data,
                            cur_row, cur_col, busy, overflow}, 64'd0);
    wr_before = wr_cnt;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("post_rst_nowr", 64'(wr_cnt - wr_before), 64'd0);
    check("post_rst_cur", {57'd0, cur_row, cur_col}, 64'd0);

    check("wq_empty", 64'(wq.size()), 64'd0);
    check("txq_empty", 64'(txq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
